// File: rtl/pll_rst_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding and
// the sizing helper for its shared cycle counter.
package pll_rst_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABLE    = 3'd1,
        ST_REL_CORE  = 3'd2,
        ST_RUN       = 3'd3,
        ST_LOST      = 3'd4
    } pll_rst_state_e;

    // One spare bit above the largest terminal count so the counter can never wrap.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for lock indications and other async inputs.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two back-to-back flops; both cleared by the synchronous reset.
    always_ff @(posedge clock_in) begin
        if (rst_in) begin
            meta_r <= '0;
            sync_r <= '0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock, releases core then peripheral resets, and on lock loss
// or forced restart re-asserts them while pulsing the PLL lock-steady reset.
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int STABLE_CYCLES   = 4800,
    parameter int STAGE_GAP       = 16,
    parameter int STDY_RST_CYCLES = 4,
    parameter int LOSS_CNT_W      = 8
) (
    input  logic                  clock_in,
    input  logic                  rst_in,
    input  logic                  locked_in,
    input  logic                  force_rst_in,
    output logic                  rst_core_out,
    output logic                  rst_periph_out,
    output logic                  ready_out,
    output logic                  lock_stdy_rst_out,
    output logic [LOSS_CNT_W-1:0] loss_count_out
);

    localparam int CNT_W = cnt_width(STABLE_CYCLES, STAGE_GAP, STDY_RST_CYCLES);
    // The WAIT_LOCK exit edge is the first qualifying cycle, so STABLE stops one short.
    localparam int STABLE_LAST_I = (STABLE_CYCLES > 1) ? (STABLE_CYCLES - 2) : 0;
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_LAST_I);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] STDY_LAST   = CNT_W'(STDY_RST_CYCLES - 1);
    localparam logic [LOSS_CNT_W-1:0] LOSS_MAX = '1;

    pll_rst_state_e        state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  rst_core_r;
    logic                  rst_periph_r;
    logic                  ready_r;
    logic                  stdy_rst_r;
    logic [LOSS_CNT_W-1:0] loss_cnt_r;

    logic locked_s;
    logic active_s;
    logic loss_s;
    logic abort_s;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clock_in (clock_in),
        .rst_in   (rst_in),
        .d        (locked_in),
        .q        (locked_s)
    );

    // Abort conditions: a counted lock loss once released, or a forced restart.
    always_comb begin
        active_s = 1'b0;
        loss_s   = 1'b0;
        abort_s  = 1'b0;
        if ((state_r == ST_REL_CORE) || (state_r == ST_RUN)) begin
            active_s = 1'b1;
        end else begin
            active_s = 1'b0;
        end
        loss_s  = active_s && !locked_s;
        abort_s = loss_s || (force_rst_in && (active_s || (state_r == ST_STABLE)));
    end

    // Sequencer FSM with registered outputs; reset beats abort beats progression.
    always_ff @(posedge clock_in) begin
        if (rst_in) begin
            state_r      <= ST_WAIT_LOCK;
            cnt_r        <= '0;
            rst_core_r   <= 1'b1;
            rst_periph_r <= 1'b1;
            ready_r      <= 1'b0;
            stdy_rst_r   <= 1'b0;
            loss_cnt_r   <= '0;
        end else if (abort_s) begin
            state_r      <= ST_LOST;
            cnt_r        <= '0;
            rst_core_r   <= 1'b1;
            rst_periph_r <= 1'b1;
            ready_r      <= 1'b0;
            stdy_rst_r   <= 1'b1;
            if (loss_s && (loss_cnt_r != LOSS_MAX)) begin
                loss_cnt_r <= loss_cnt_r + LOSS_CNT_W'(1);
            end else begin
                loss_cnt_r <= loss_cnt_r;
            end
        end else begin
            case (state_r)
                ST_WAIT_LOCK: begin
                    cnt_r <= '0;
                    if (locked_s && !force_rst_in) begin
                        if (STABLE_CYCLES == 1) begin
                            state_r    <= ST_REL_CORE;
                            rst_core_r <= 1'b0;
                        end else begin
                            state_r <= ST_STABLE;
                        end
                    end else begin
                        state_r <= ST_WAIT_LOCK;
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state_r <= ST_WAIT_LOCK;
                        cnt_r   <= '0;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_r    <= ST_REL_CORE;
                        cnt_r      <= '0;
                        rst_core_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_REL_CORE: begin
                    if (cnt_r == GAP_LAST) begin
                        state_r      <= ST_RUN;
                        cnt_r        <= '0;
                        rst_periph_r <= 1'b0;
                        ready_r      <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    state_r <= ST_RUN;
                end
                ST_LOST: begin
                    if (cnt_r == STDY_LAST) begin
                        state_r    <= ST_WAIT_LOCK;
                        cnt_r      <= '0;
                        stdy_rst_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r      <= ST_WAIT_LOCK;
                    cnt_r        <= '0;
                    rst_core_r   <= 1'b1;
                    rst_periph_r <= 1'b1;
                    ready_r      <= 1'b0;
                    stdy_rst_r   <= 1'b0;
                end
            endcase
        end
    end

    assign rst_core_out      = rst_core_r;
    assign rst_periph_out    = rst_periph_r;
    assign ready_out         = ready_r;
    assign lock_stdy_rst_out = stdy_rst_r;
    assign loss_count_out    = loss_cnt_r;

endmodule
